// File: rtl/ifetch_resp_pkg.sv
// Shared definitions for the instruction-fetch response block: NOP encoding,
// stall-vector decoding, FSM state encodings and default widths.
// Ports: none (package). Imported by ifetch_resp and ifetch_tmo.
package ifetch_resp_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  // addi x0, x0, 0 -- what the decoder sees whenever no real instruction is held
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Bit of the stall vector that freezes the IF/ID boundary, and its active level
  localparam int unsigned STALL_IF_BIT = 1;
  localparam logic        STOP         = 1'b1;

  // FSM encodings; 2'b11 is illegal and recovers to IDLE
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_tmo.sv
// Fetch timeout counter: counts enabled cycles and flags the last allowed one.
// Ports: clk, rst_n (async active-low), clr (synchronous clear), en (count),
//        expire (combinational, high during the TMO_CYCLES-th enabled cycle).
module ifetch_tmo
  import ifetch_resp_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TMO_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt starts at 0 in the first enabled cycle, so equality with LAST marks
  // the TMO_CYCLES-th cycle; the owner leaves the counting state on that edge.
  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch response stage: issues one memory read per new aligned PC,
// holds the returned instruction for the decoder and suppresses re-fetches.
// Ports: clk_i/rst_i (async active-low), ce_i/pc_i/stall_i from the pipeline,
//        inst_o/inst_valid_o/stallreq_o/fetch_err_o to it, mem_req_o/mem_addr_o
//        and mem_ack_i/mem_rdata_i to memory. Optional timeout: IFETCH_TIMEOUT_EN.
module ifetch_resp
  import ifetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [5:0]            stall_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o,
  output logic                  stallreq_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  fetch_err_o
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INST);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  fetch_err;
  logic                  tmo_expire;
  logic                  freeze;
  logic                  misalign;

  assign freeze   = (stall_i[STALL_IF_BIT] == STOP);
  assign misalign = !word_aligned(pc_i[1:0]);

  // Only the IF/ID stall bit matters here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

`ifdef IFETCH_TIMEOUT_EN
  ifetch_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .clr    (state != S_REQ),
    .en     (state == S_REQ),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
  logic unused_tmo;
  assign unused_tmo = TMO_CYCLES[0];
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      inst       <= NOP;
      inst_valid <= 1'b0;
      held_addr  <= '0;
      mem_addr   <= '0;
      fetch_err  <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      if (!ce_i) begin
        // Fetch disabled wins over everything, including an ack this cycle.
        state      <= S_IDLE;
        inst       <= NOP;
        inst_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // Entering IDLE drops the held instruction, so IDLE always fetches.
            if (misalign) begin
              if (!freeze) begin
                state      <= S_HOLD;
                inst       <= NOP;
                inst_valid <= 1'b1;
                held_addr  <= pc_i;
                fetch_err  <= 1'b1;
              end
            end else begin
              state    <= S_REQ;
              mem_addr <= pc_i;
            end
          end
          S_REQ: begin
            // The ack is a single-cycle pulse, so it is captured even under a
            // stall; dropping it would leave the fetch hung.
            if (mem_ack_i) begin
              state      <= S_HOLD;
              inst       <= mem_rdata_i;
              inst_valid <= 1'b1;
              held_addr  <= mem_addr;
            end else if (tmo_expire) begin
              state      <= S_HOLD;
              inst       <= NOP;
              inst_valid <= 1'b1;
              held_addr  <= mem_addr;
              fetch_err  <= 1'b1;
            end
          end
          S_HOLD: begin
            // Held address is recorded even for a misaligned PC so that the
            // error pulses once per bad address rather than every cycle.
            if (!freeze && (pc_i != held_addr)) begin
              if (misalign) begin
                inst       <= NOP;
                inst_valid <= 1'b1;
                held_addr  <= pc_i;
                fetch_err  <= 1'b1;
              end else begin
                state      <= S_REQ;
                inst_valid <= 1'b0;
                mem_addr   <= pc_i;
              end
            end
          end
          default: begin
            state      <= S_IDLE;
            inst       <= NOP;
            inst_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign inst_o       = inst;
  assign inst_valid_o = inst_valid;
  assign mem_req_o    = (state == S_REQ);
  assign stallreq_o   = (state == S_REQ);
  assign mem_addr_o   = mem_addr;
  assign fetch_err_o  = fetch_err;

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp: reset, fetch latency, re-fetch suppression,
// misalignment, stall freeze, ce drop with ack, reset mid-fetch, timeout.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_ifetch_resp;

  logic        clk_i;
  logic        rst_i;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [5:0]  stall_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        fetch_err_o;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_resp #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TMO_CYCLES (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .fetch_err_o  (fetch_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; ce_i = 1'b0; pc_i = 32'h0; stall_i = 6'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    step(); step();
    n_cmp++; if (inst_o !== 32'h00000013) begin n_err++; $display("FAIL reset_inst got=%h exp=%h", inst_o, 32'h00000013); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
    n_cmp++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL reset_stallreq got=%b exp=0", stallreq_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    n_cmp++; if (fetch_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", fetch_err_o); end
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    int stall_cycles;
    ce_i = 1'b1; pc_i = 32'h0;
    step();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL fetch_req got=%b exp=1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL fetch_addr got=%h exp=0", mem_addr_o); end
    stall_cycles = (stallreq_o === 1'b1) ? 1 : 0;
    step();
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL fetch_addr_stable got=%h exp=0", mem_addr_o); end
    if (stallreq_o === 1'b1) stall_cycles++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00500093;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    if (stallreq_o === 1'b1) stall_cycles++;
    n_cmp++; if (stall_cycles !== 2) begin n_err++; $display("FAIL fetch_stall_cycles got=%0d exp=2", stall_cycles); end
    n_cmp++; if (inst_o !== 32'h00500093) begin n_err++; $display("FAIL fetch_inst got=%h exp=00500093", inst_o); end
    n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL fetch_valid got=%b exp=1", inst_valid_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL fetch_req_drop got=%b exp=0", mem_req_o); end
  endtask

  task automatic test_hold();
    pc_i = 32'h4;
    step();
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_newpc_valid got=%b exp=0", inst_valid_o); end
    n_cmp++; if (mem_addr_o !== 32'h4) begin n_err++; $display("FAIL hold_newpc_addr got=%h exp=4", mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00A00113;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      // a stray ack with no request outstanding must be ignored
      if (i == 2) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0; end
      else begin mem_ack_i = 1'b0; mem_rdata_i = 32'h0; end
      step();
      n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d] got=%b exp=0", i, mem_req_o); end
      n_cmp++; if (inst_o !== 32'h00A00113) begin n_err++; $display("FAIL hold_inst[%0d] got=%h exp=00a00113", i, inst_o); end
    end
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  task automatic test_misalign();
    pc_i = 32'h6;
    step();
    n_cmp++; if (fetch_err_o !== 1'b1) begin n_err++; $display("FAIL mis_err got=%b exp=1", fetch_err_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL mis_req got=%b exp=0", mem_req_o); end
    n_cmp++; if (inst_o !== 32'h00000013) begin n_err++; $display("FAIL mis_inst got=%h exp=00000013", inst_o); end
    n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL mis_valid got=%b exp=1", inst_valid_o); end
    step();
    n_cmp++; if (fetch_err_o !== 1'b0) begin n_err++; $display("FAIL mis_err_pulse got=%b exp=0", fetch_err_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL mis_req2 got=%b exp=0", mem_req_o); end
  endtask

  task automatic test_stall();
    pc_i = 32'h8;
    step();
    n_cmp++; if (mem_addr_o !== 32'h8) begin n_err++; $display("FAIL stall_addr8 got=%h exp=8", mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00108093;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    stall_i = 6'b000010; pc_i = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (inst_o !== 32'h00108093) begin n_err++; $display("FAIL stall_inst[%0d] got=%h exp=00108093", i, inst_o); end
      n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, inst_valid_o); end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got=%b exp=0", i, mem_req_o); end
    end
    stall_i = 6'h0;
    step();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL stall_rel_req got=%b exp=1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'hC) begin n_err++; $display("FAIL stall_rel_addr got=%h exp=c", mem_addr_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_rel_valid got=%b exp=0", inst_valid_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00210113;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if (inst_o !== 32'h00210113) begin n_err++; $display("FAIL stall_fetchC got=%h exp=00210113", inst_o); end
  endtask

  task automatic test_ce_drop();
    pc_i = 32'h10;
    step();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL ce_pre_req got=%b exp=1", mem_req_o); end
    ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL ce_req got=%b exp=0", mem_req_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL ce_valid got=%b exp=0", inst_valid_o); end
    n_cmp++; if (inst_o !== 32'h00000013) begin n_err++; $display("FAIL ce_inst got=%h exp=00000013", inst_o); end
    n_cmp++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL ce_stallreq got=%b exp=0", stallreq_o); end
    ce_i = 1'b1;
    step();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL ce_refetch_req got=%b exp=1", mem_req_o); end
  endtask

  task automatic test_reset_in_req();
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rreq_async_req got=%b exp=0", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rreq_async_addr got=%h exp=0", mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    step();
    rst_i = 1'b1;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if (inst_o !== 32'h00000013) begin n_err++; $display("FAIL rreq_inst got=%h exp=00000013", inst_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rreq_valid got=%b exp=0", inst_valid_o); end
    n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL rreq_newreq got=%b exp=1", mem_req_o); end
  endtask

`ifdef IFETCH_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    rst_i = 1'b0; ce_i = 1'b0;
    step();
    rst_i = 1'b1; ce_i = 1'b1; pc_i = 32'h20;
    step();
    req_cycles = 0;
    while (mem_req_o === 1'b1 && req_cycles < 20) begin
      req_cycles++;
      step();
    end
    n_cmp++; if (req_cycles !== 4) begin n_err++; $display("FAIL tmo_cycles got=%0d exp=4", req_cycles); end
    n_cmp++; if (fetch_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err got=%b exp=1", fetch_err_o); end
    n_cmp++; if (inst_o !== 32'h00000013) begin n_err++; $display("FAIL tmo_inst got=%h exp=00000013", inst_o); end
    n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL tmo_valid got=%b exp=1", inst_valid_o); end
    step();
    n_cmp++; if (fetch_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_err_pulse got=%b exp=0", fetch_err_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL tmo_no_retry got=%b exp=0", mem_req_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_hold();
    test_misalign();
    test_stall();
    test_ce_drop();
    test_reset_in_req();
`ifdef IFETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_resp.md
IFETCH_RESP -- requirements
Module: ifetch_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the fetch address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction width.
REQ-003 Parameter TMO_CYCLES, default 255, SHALL set the maximum wait cycles for mem_ack_i (range 1..255).
REQ-004 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 ce_i  in  1  SHALL be the fetch enable from the PC generator.
REQ-007 pc_i  in  ADDR_WIDTH  SHALL be the fetch address from the PC generator.
REQ-008 stall_i  in  6  SHALL be the pipeline stall vector; bit 1 freezes the IF/ID boundary.
REQ-009 inst_o  out  DATA_WIDTH  SHALL be the fetched instruction.
REQ-010 inst_valid_o  out  1  SHALL be high when inst_o holds the instruction for the current pc_i.
REQ-011 stallreq_o  out  1  SHALL request a pipeline stall while a fetch is outstanding.
REQ-012 mem_req_o / mem_addr_o  out  1 / ADDR_WIDTH  SHALL be the memory read request and word address.
REQ-013 mem_ack_i / mem_rdata_i  in  1 / DATA_WIDTH  SHALL be the one-cycle memory acknowledge and read data.
REQ-014 fetch_err_o  out  1  SHALL pulse for one cycle on misalignment or timeout.

Function
REQ-015 FSM states IDLE, REQ, HOLD SHALL be the only states; illegal encodings SHALL return to IDLE.
REQ-016 IDLE: ce_i=1 with aligned pc_i, not matching a valid held address, SHALL go to REQ.
REQ-017 REQ: mem_req_o=1, mem_addr_o=registered pc_i, stallreq_o=1; both SHALL stay stable until mem_ack_i is sampled high.
REQ-018 mem_ack_i sampled high at edge N SHALL capture mem_rdata_i into inst_o, set inst_valid_o=1, drop mem_req_o and stallreq_o after edge N, go to HOLD (latency: ack-to-valid 0 extra cycles, registered).
REQ-019 HOLD: pc_i equal to the held address SHALL issue no memory request (re-fetch suppressed).
REQ-020 HOLD: pc_i changing while stall_i[1]=0 SHALL clear inst_valid_o and go to REQ next edge.
REQ-021 stall_i[1]=1 SHALL freeze inst_o, inst_valid_o and the held address regardless of pc_i.
REQ-022 ce_i=0 in any state SHALL go to IDLE, drive mem_req_o=0, inst_o=NOP_INST, inst_valid_o=0, stallreq_o=0.
REQ-023 mem_ack_i arriving in the same cycle ce_i falls SHALL be discarded.
REQ-024 pc_i[1:0]!=0 with ce_i=1 SHALL issue no request, pulse fetch_err_o, drive inst_o=NOP_INST with inst_valid_o=1.
REQ-025 mem_ack_i while mem_req_o=0 SHALL be ignored.

Reset
REQ-026 rst_i=0 SHALL asynchronously force IDLE, inst_o=NOP_INST, inst_valid_o=0, stallreq_o=0, mem_req_o=0, mem_addr_o=0, fetch_err_o=0, held address and timeout counter=0.
REQ-027 Reset during REQ SHALL abandon the fetch; no capture occurs after release.

Configuration
REQ-028 With IFETCH_TIMEOUT_EN defined, an 8-bit counter SHALL count REQ cycles; reaching TMO_CYCLES SHALL drop mem_req_o, pulse fetch_err_o, output NOP_INST with inst_valid_o=1, go to HOLD.
REQ-029 Without IFETCH_TIMEOUT_EN, no counter SHALL exist and REQ SHALL wait indefinitely for mem_ack_i.

Structure
REQ-030 NOP_INST (32'h00000013), STOP, state encodings and ADDR_WIDTH default SHALL live in the shared defines package.
REQ-031 The timeout counter SHALL be sub-module ifetch_tmo (clear, enable, expire pulse), instantiated only under IFETCH_TIMEOUT_EN.

Verification
REQ-032 ce_i=1, pc_i=0x0, mem_ack_i 2 cycles after req, rdata 0x00500093 -> stallreq_o high 2 cycles, inst_o=0x00500093, inst_valid_o=1.
REQ-033 pc_i held at 0x4 in HOLD for 5 cycles -> mem_req_o stays 0, inst_o unchanged.
REQ-034 pc_i=0x6 -> no mem_req_o, fetch_err_o one-cycle pulse, inst_o=0x00000013.
REQ-035 ce_i dropped in REQ simultaneous with mem_ack_i -> IDLE, inst_valid_o=0, rdata not captured.
REQ-036 IFETCH_TIMEOUT_EN, TMO_CYCLES=4, no ack -> mem_req_o drops after 4 cycles, fetch_err_o pulse, inst_o=0x00000013.
REQ-037 stall_i[1]=1 while pc_i moves 0x8->0xC -> inst_o frozen; on release, fetch of 0xC issued.
